// File: rtl/bcd_7seg_scan.sv
// bcd_7seg_scan: time-multiplexed driver for a common-segment 7-segment display.
// Captures a packed BCD word on load and lights one digit at a time, CLK_DIV
// cycles per digit. Supports leading-zero blanking and shows a dash for
// invalid BCD nibbles.
//
// Ports:
//   clk        rising-edge system clock
//   rst        asynchronous active-high reset
//   bcd_in     packed BCD, nibble k = bcd_in[4k+3:4k], k=0 least significant
//   load       capture strobe for bcd_in (re-captures every edge while high)
//   seg        registered segment drive, active-high, seg[0]=a .. seg[6]=g
//   an         registered one-hot digit enable, an[k] lights digit k
//   frame_done registered one-cycle pulse on the edge the scan wraps to digit 0
module bcd_7seg_scan #(
  parameter int unsigned NDIG     = 3,
  parameter int unsigned CLK_DIV  = 4,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] bcd_in,
  input  logic              load,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic              frame_done
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [PW-1:0] PreLast = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IdxLast = IW'(NDIG - 1);

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40; // invalid BCD: dash
    endcase
    return s;
  endfunction

  logic [4*NDIG-1:0] disp_q, disp_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic              fd_q, fd_d;

  logic [NDIG-1:0]   blank;
  logic [3:0]        cur_nib;
  logic              cur_blank;
  logic              slot_end;

  // Digit k blanks when it and every more significant nibble is zero; digit 0
  // never blanks. Invalid nibbles are nonzero and so stop the blanking run.
  always_comb begin
    logic upper_zero;
    blank      = '0;
    upper_zero = 1'b1;
    for (int k = NDIG - 1; k >= 0; k--) begin
      upper_zero = upper_zero & (disp_q[4*k +: 4] == 4'd0);
      if (BLANK_LZ && (k > 0)) begin
        blank[k] = upper_zero;
      end
    end
  end

  always_comb begin
    cur_nib   = 4'd0;
    cur_blank = 1'b0;
    an_d      = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (idx_q == IW'(k)) begin
        cur_nib   = disp_q[4*k +: 4];
        cur_blank = blank[k];
        an_d[k]   = 1'b1;
      end
    end
  end

  always_comb begin
    slot_end = (pre_q == PreLast);
    disp_d   = load ? bcd_in : disp_q;
    pre_d    = slot_end ? '0 : pre_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
    seg_d = cur_blank ? 7'h00 : seg_decode(cur_nib);
    fd_d  = slot_end && (idx_q == IdxLast);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q <= '0;
      pre_q  <= '0;
      idx_q  <= '0;
      seg_q  <= 7'h00;
      an_q   <= '0;
      fd_q   <= 1'b0;
    end else begin
      disp_q <= disp_d;
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      fd_q   <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Bench for bcd_7seg_scan: three instances (CLK_DIV=4 with blanking, CLK_DIV=1
// with blanking, CLK_DIV=4 without blanking) share stimulus and are checked
// every cycle against a reference derived from elapsed cycles and a segment table.
module tb_bcd_7seg_scan;

  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [11:0] bcd_in;
  logic [6:0]  seg_o [3];
  logic [2:0]  an_o  [3];
  logic        fd_o  [3];

  int          checks = 0;
  int          errors = 0;
  int          t;       // edges since reset release
  logic [11:0] disp_m;  // value the display holds before the coming edge

  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  always #5 clk = ~clk;

  bcd_7seg_scan #(.NDIG(3), .CLK_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load),
    .seg(seg_o[0]), .an(an_o[0]), .frame_done(fd_o[0])
  );

  bcd_7seg_scan #(.NDIG(3), .CLK_DIV(1), .BLANK_LZ(1'b1)) dut_fast (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load),
    .seg(seg_o[1]), .an(an_o[1]), .frame_done(fd_o[1])
  );

  bcd_7seg_scan #(.NDIG(3), .CLK_DIV(4), .BLANK_LZ(1'b0)) dut_noblank (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load),
    .seg(seg_o[2]), .an(an_o[2]), .frame_done(fd_o[2])
  );

  function automatic logic [6:0] ref_seg(input logic [11:0] d, input int k, input bit blz);
    logic [11:0] upper;
    logic [3:0]  nib;
    upper = d >> (4 * k);
    nib   = upper[3:0];
    if (blz && k > 0 && upper == 12'd0) return 7'h00;
    return seg_tbl[nib];
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input int inst, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst=%0d t=%0d observed=%h expected=%h", tag, inst, t, obs, exp);
    end
  endtask

  // One clock edge with the given load/bcd_in; all three instances checked.
  task automatic step(input bit ld, input logic [11:0] val);
    int cd;
    int k;
    bit blz;
    load   = ld;
    bcd_in = val;
    @(posedge clk);
    t++;
    #1;
    for (int c = 0; c < 3; c++) begin
      cd  = (c == 1) ? 1 : 4;
      blz = (c != 2);
      k   = ((t - 1) / cd) % ND;
      check("seg", c, {1'b0, seg_o[c]}, {1'b0, ref_seg(disp_m, k, blz)});
      check("an", c, {5'b0, an_o[c]}, 8'(1 << k));
      check("frame_done", c, {7'b0, fd_o[c]}, {7'b0, (t % (ND * cd)) == 0});
    end
    if (ld) disp_m = val;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 12'h000);
  endtask

  // Asynchronous reset asserted and released between clock edges.
  task automatic reset_pulse();
    @(posedge clk);
    #3;
    rst  = 1'b1;
    load = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      check("rst_seg", c, {1'b0, seg_o[c]}, 8'h00);
      check("rst_an", c, {5'b0, an_o[c]}, 8'h00);
      check("rst_fd", c, {7'b0, fd_o[c]}, 8'h00);
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) check("rst_hold_an", c, {5'b0, an_o[c]}, 8'h00);
    @(negedge clk);
    rst    = 1'b0;
    t      = 0;
    disp_m = 12'h000;
  endtask

  initial begin
    rst    = 1'b1;
    load   = 1'b0;
    bcd_in = 12'h000;
    t      = 0;
    disp_m = 12'h000;
    reset_pulse();

    run(12);                       // value 0: single "0", upper digits blank
    step(1'b1, 12'h255); run(26);
    step(1'b1, 12'h007); run(12);
    step(1'b1, 12'h070); run(12);
    step(1'b1, 12'h1A3); run(12);
    step(1'b1, 12'h0B0); run(12);
    // Land a load inside digit 1's slot of the CLK_DIV=4 scan.
    step(1'b1, 12'h111); run(5);
    step(1'b1, 12'h999); run(12);
    // load held high over several edges
    for (int i = 0; i < 4; i++) step(1'b1, 12'($urandom));
    run(7);

    reset_pulse();                 // mid-scan reset loses the display word
    run(13);

    for (int v = 0; v < 256; v++) begin
      step(1'b1, to_bcd(v));
      run(2);
    end

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 6) == 0, 12'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
